mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit that supplies the HI/LO results for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It is the sequential companion to the single-cycle ALU: the ALU answers add, sub, logic and shift in one cycle, while this block accepts a start request from the controller, holds busy for the iteration, and returns a registered 64-bit result. It sits beside the ALU in the execute stage, and the controller stalls on `busy`.

## Interface
- No parameters. Data width is fixed at 32; iteration count is fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: operation request, sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in 32: multiplicand or dividend (rs).
- `b` in 32: multiplier or divisor (rt).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when HI/LO have been updated, or when a divide is rejected.
- `div_zero` out 1: one-cycle pulse with `done` on a divide by zero.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: 32 iterations, `busy`=1.
  - FIX: sign correction and HI/LO write, `busy`=1.
- IDLE with `start`=1, non-zero divisor or multiply op:
  - latch `op`;
  - latch |a| and |b| (magnitudes only for signed ops, raw for unsigned);
  - latch the result sign (a[31]^b[31]) and the dividend sign;
  - counter cleared to 0; go to CALC.
- IDLE with `start`=1, divide op, `b`==0:
  - no state change; HI/LO unchanged;
  - `done`=1 and `div_zero`=1 for one cycle.
- CALC, multiply: shift-add of the 32-bit magnitudes into a 64-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; 33-bit partial remainder, subtract, keep the result if non-negative.
- Counter 0..31; after iteration 31 go to FIX.
- FIX:
  - negate the product, quotient or remainder as required;
  - write HI/LO; pulse `done`; return to IDLE.
- Multiply result: {HI,LO} = full 64-bit product, two's complement for MULT.
- Divide result:
  - LO = quotient, truncated toward zero;
  - HI = remainder, carrying the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is not flagged.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write `wdata` at the clock edge, only while `busy`=0; ignored while busy;
  - if a write coincides with an accepted `start`, the write happens now and is overwritten at FIX.
- `start` while busy is ignored; no queueing.
- `a`, `b` and `op` may change after the start edge; only latched copies are used.

## Timing
- Reset (asynchronous, any state): state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, counter 0.
- Reset mid-operation aborts the operation; HI/LO return to 0.
- `start` is accepted at edge E0.
- `busy` is high after E0 through E33 (CALC covers E1..E32; FIX is the cycle after E32).
- At E33: HI/LO are written, `done` is high for the following cycle, and `busy` is low in that same cycle.
- Total latency: HI/LO are valid 33 edges after the start edge.
- A new `start` may be asserted in the `done` cycle and is accepted.
- Divide by zero: the `done`/`div_zero` pulse occurs in the cycle after E0, `busy` never rises, and the unit is ready again the next cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then MULT with a=0xFFFFFFFD (-3), b=7 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB; `done` for 1 cycle; `busy` high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT with the same operands -> HI=0, LO=1.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO 0x1234 then DIVU 5/0 -> `done` and `div_zero` pulse next cycle, `busy` stays 0, LO=0x1234 and HI unchanged.
- During a MULT:
  - pulse `start` with DIVU, and pulse `hi_we` with 0xAAAA -> both ignored; the MULT result is correct; `done` pulses once.
  - back-to-back `start` in the `done` cycle -> accepted.
- Drop `rst_n` at iteration 15 -> `busy`=0, HI=LO=0 immediately; a subsequent MULT 6×7 gives LO=42.

Source files
------------

// File: rtl/mul_div_if.sv
// Controller <-> multiply/divide unit bundle: request side, MTHI/MTLO writes,
// status pulses and the architectural HI/LO registers.
interface mul_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    // Controller side
    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    // Unit side
    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO unit for MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Works on operand magnitudes for 32 shift-add / restoring-divide steps,
// then applies sign correction and writes HI/LO in a final FIX cycle.
module mul_div_unit (
    input  logic      clk,
    input  logic      rst_n,
    mul_div_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;     // only op[1] matters after sign flags are folded in
    logic        neg_res_q, neg_res_d;   // negate product / quotient
    logic        neg_rem_q, neg_rem_d;   // negate remainder (dividend was negative)
    logic [31:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
    logic [63:0] acc_q, acc_d;           // mul: {partial, multiplier}; div: {rem, dividend/quot}
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic        busy_q, busy_d;

    logic        in_div, in_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;

    // One iteration step for each operation, plus input magnitudes.
    always_comb begin
        in_div    = bus.op[1];
        in_signed = bus.op[0];
        mag_a     = (in_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
        mag_b     = (in_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

        // Shift-add: add multiplicand into the upper half when the multiplier LSB is set
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};

        // Restoring division: bit 32 of the difference is the borrow
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[32]) begin
            div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
        end else begin
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        end

        prod_fix  = neg_res_q ? (64'd0 - acc_q) : acc_q;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // MTHI/MTLO land now even if a start is accepted; FIX overwrites later
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    if (in_div && (bus.b == 32'd0)) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        is_div_d  = in_div;
                        neg_res_d = in_signed & (bus.a[31] ^ bus.b[31]);
                        neg_rem_d = in_signed & bus.a[31];
                        opnd_d    = in_div ? mag_b : mag_a;
                        acc_d     = {32'd0, in_div ? mag_a : mag_b};
                        cnt_d     = 5'd0;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
                    hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected HI/LO into a
// scoreboard, a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;

    localparam logic [1:0] OpMultu = 2'b00;
    localparam logic [1:0] OpMult  = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpDiv   = 2'b11;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    mul_div_if bus ();

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] prev_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                mon_e = sb.pop_front();
                check("hi", bus.hi, mon_e.hi);
                check("lo", bus.lo, mon_e.lo);
                check("div_zero", {31'd0, bus.div_zero}, {31'd0, mon_e.dz});
                check("busy_in_done", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    // Called away from a clock edge; returns 1 time unit after the start edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic dz);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = dz;
        sb.push_back(e);
        if (!dz) begin
            m_hi = ehi;
            m_lo = elo;
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        // Operands are free to change once accepted
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
    endtask

    // Counts busy cycles until done; returns at the negedge inside the done cycle.
    task automatic wait_done(input string name, input int exp_busy);
        int  n    = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) n++;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done in 100 cycles, expected done", name);
        end else begin
            check({name, "_busy_cycles"}, n, exp_busy);
        end
    endtask

    // MTHI/MTLO write, called at a negedge while idle; returns at a negedge.
    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        bus.hi_we = h;
        bus.lo_we = l;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        @(negedge clk);
        check("mt_hi", bus.hi, m_hi);
        check("mt_lo", bus.lo, m_lo);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_dz", {31'd0, bus.div_zero}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OpMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done("mult_m3x7", 33);
        // Each following issue starts inside the previous done cycle
        issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done("multu_max", 33);
        issue(OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        wait_done("mult_m1xm1", 33);
        issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done("div_m7_2", 33);
        issue(OpDivu, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        wait_done("divu_7_2", 33);
        issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_done("div_ovf", 33);

        @(negedge clk);
        mt(1'b0, 1'b1, 32'h0000_1234);
        issue(OpDivu, 32'd5, 32'd0, m_hi, 32'h0000_1234, 1'b1);
        wait_done("divu_by0", 0);
        @(negedge clk);
        check("by0_busy_after", {31'd0, bus.busy}, 32'd0);

        mt(1'b1, 1'b0, 32'h0000_5555);
        prev_hi = m_hi;
        issue(OpMult, 32'h0001_2345, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFD_B976, 1'b0);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OpDivu;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        @(negedge clk);
        check("busy_hi_we_ignored", bus.hi, prev_hi);
        check("busy_mid_op", {31'd0, bus.busy}, 32'd1);
        wait_done("mult_interfered", 27);

        issue(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done("divu_100_7", 33);
        issue(OpDiv, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
        wait_done("div_100_m7", 33);
        issue(OpDiv, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        wait_done("div_m100_7", 33);

        // Abort a multiply part way through CALC
        issue(OpMult, 32'd5, 32'd9, 32'd0, 32'd45, 1'b0);
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        sb.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OpMult, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        wait_done("mult_6x7", 33);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
